// File: rtl/stereo_sample_player_pkg.sv
// rtl/stereo_sample_player_pkg.sv - shared state encoding and helpers for the stereo player
// Purpose: FSM state constants and the midscale helper used by the player top.
// Ports: none (package).
package stereo_sample_player_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_RD_L  = 3'd2;
  localparam logic [2:0] ST_RD_R  = 3'd3;
  localparam logic [2:0] ST_CAP_R = 3'd4;

  // Offset-binary silence level for a dw-bit sample.
  function automatic int midscale(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/stereo_sample_player_dac.sv
// rtl/stereo_sample_player_dac.sv - first-order delta-sigma 1-bit DAC for one channel
// Purpose: converts an offset-binary sample into a pulse-density bit stream.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   din   - DW-bit offset-binary sample
//   dout  - registered 1-bit density output (IOB friendly)
module sigma_delta_dac_n #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  output logic          dout
);

  logic [DW:0] acc_q;
  logic        dout_q;

  // The carry out of the previous add becomes the output bit, then is
  // dropped so the accumulator only ever carries its DW-bit remainder.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      acc_q  <= {1'b0, acc_q[DW-1:0]} + {1'b0, din};
      dout_q <= acc_q[DW];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/stereo_sample_player.sv
// rtl/stereo_sample_player.sv - interleaved stereo PCM player with delta-sigma outputs
// Purpose: fetches L/R frames from a synchronous sample memory once per DIV
//   clocks and drives one delta-sigma bit per channel.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, stop           - one-cycle control requests (stop wins)
//   loop, base_addr,
//   frame_count           - playback setup, sampled at start
//   mem_addr, mem_rd      - sample memory read request
//   mem_data              - read data, valid the cycle after mem_rd
//   busy, done            - status (done is a one-cycle pulse)
//   left, right           - delta-sigma channel outputs
module stereo_sample_player
  import stereo_sample_player_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 12,
  parameter int DIV = 7000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-2:0] frame_count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic          left,
  output logic          right
);

  localparam int            PW      = $clog2(DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] MID     = DW'(midscale(DW));

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [AW-2:0] frame_idx_q, frame_idx_d;
  logic [AW-2:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          loop_q, loop_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          done_q, done_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] held_l_q, held_l_d;
  logic [DW-1:0] held_r_q, held_r_d;
  logic          tick;

  assign tick = (ps_q == PS_LAST);

  always_comb begin
    state_d     = state_q;
    ps_d        = ps_q;
    frame_idx_d = frame_idx_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    loop_d      = loop_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    done_d      = 1'b0;
    pend_d      = pend_q;
    held_l_d    = held_l_q;
    held_r_d    = held_r_q;

    // Free-running through the read states keeps the frame period at DIV.
    if (state_q != ST_IDLE) ps_d = tick ? '0 : ps_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (frame_count == '0) begin
            done_d = 1'b1;
          end else begin
            loop_d      = loop;
            base_d      = base_addr;
            cnt_d       = frame_count;
            frame_idx_d = '0;
            ps_d        = '0;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (tick) begin
          addr_d  = base_q + {frame_idx_q, 1'b0};
          rd_d    = 1'b1;
          state_d = ST_RD_L;
        end
      end
      ST_RD_L: begin
        addr_d  = addr_q + 1'b1;
        rd_d    = 1'b1;
        state_d = ST_RD_R;
      end
      ST_RD_R: begin
        pend_d  = mem_data;
        rd_d    = 1'b0;
        state_d = ST_CAP_R;
      end
      ST_CAP_R: begin
        // Both channels change on the same edge so the image never skews.
        held_l_d = pend_q;
        held_r_d = mem_data;
        if (frame_idx_q != cnt_q - 1'b1) begin
          frame_idx_d = frame_idx_q + 1'b1;
          state_d     = ST_WAIT;
        end else if (loop_q) begin
          frame_idx_d = '0;
          state_d     = ST_WAIT;
        end else begin
          done_d   = 1'b1;
          held_l_d = MID;
          held_r_d = MID;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      rd_d     = 1'b0;
      done_d   = 1'b0;
      held_l_d = MID;
      held_r_d = MID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ps_q        <= '0;
      frame_idx_q <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      loop_q      <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= MID;
      held_l_q    <= MID;
      held_r_q    <= MID;
    end else begin
      state_q     <= state_d;
      ps_q        <= ps_d;
      frame_idx_q <= frame_idx_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      loop_q      <= loop_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      held_l_q    <= held_l_d;
      held_r_q    <= held_r_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

  sigma_delta_dac_n #(.DW(DW)) u_dac_l (
    .clk  (clk),
    .reset(reset),
    .din  (held_l_q),
    .dout (left)
  );

  sigma_delta_dac_n #(.DW(DW)) u_dac_r (
    .clk  (clk),
    .reset(reset),
    .din  (held_r_q),
    .dout (right)
  );

endmodule

// File: tb/tb_stereo_sample_player.sv
// tb/tb_stereo_sample_player.sv - self-checking bench for stereo_sample_player
module tb_stereo_sample_player;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int DIV = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-2:0] frame_count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_data = '0;
  logic          busy, done, left, right;

  logic [7:0] mem [256];
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  stereo_sample_player #(.DW(DW), .AW(AW), .DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .base_addr  (base_addr),
    .frame_count(frame_count),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .left       (left),
    .right      (right)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: playback is a schedule counted in cycles since start.
  // Frame n is fetched at k = (n+1)*DIV (+1 for right) and heard from
  // k = (n+1)*DIV + 3. DAC output is the carry of the running sample total.
  bit         m_act = 1'b0;
  int         m_k = 0;
  logic [7:0] m_base = '0;
  int         m_cnt = 0;
  bit         m_loop = 1'b0;
  logic [7:0] e_held_l = 8'h80, e_held_r = 8'h80;
  bit         e_rd = 1'b0, e_done = 1'b0, e_left = 1'b0, e_right = 1'b0;
  logic [7:0] e_addr = '0;
  longint     tot_l = 0, tot_r = 0;
  bit         pc_l = 1'b0, pc_r = 1'b0;

  always @(posedge clk) begin
    int ph, n, fr;
    logic [7:0] la;
    e_done = 1'b0;
    if (reset) begin
      m_act = 1'b0; e_rd = 1'b0; e_addr = '0;
      e_held_l = 8'h80; e_held_r = 8'h80;
      tot_l = 0; tot_r = 0; pc_l = 1'b0; pc_r = 1'b0;
      e_left = 1'b0; e_right = 1'b0;
    end else begin
      e_left  = pc_l;
      pc_l    = (((tot_l + e_held_l) >> 8) != (tot_l >> 8));
      tot_l  += e_held_l;
      e_right = pc_r;
      pc_r    = (((tot_r + e_held_r) >> 8) != (tot_r >> 8));
      tot_r  += e_held_r;
      if (m_act) begin
        if (stop) begin
          m_act = 1'b0; e_rd = 1'b0; e_held_l = 8'h80; e_held_r = 8'h80;
        end else begin
          m_k++;
          ph = m_k % DIV;
          n  = m_k / DIV - 1;
          if (n >= 0) begin
            fr = m_loop ? (n % m_cnt) : n;
            la = 8'(m_base + 2 * fr);
            if (ph == 0) begin
              e_rd = 1'b1; e_addr = la;
            end else if (ph == 1) begin
              e_rd = 1'b1; e_addr = 8'(la + 1);
            end else if (ph == 2) begin
              e_rd = 1'b0;
            end else if (ph == 3) begin
              e_held_l = mem[la];
              e_held_r = mem[8'(la + 1)];
              if (!m_loop && fr == m_cnt - 1) begin
                e_done = 1'b1; m_act = 1'b0;
                e_held_l = 8'h80; e_held_r = 8'h80;
              end
            end
          end
        end
      end else if (start && !stop) begin
        if (frame_count == 0) e_done = 1'b1;
        else begin
          m_act = 1'b1; m_k = 0; m_base = base_addr;
          m_cnt = int'(frame_count); m_loop = loop;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_act));
      check("done", 32'(done), 32'(e_done));
      check("mem_rd", 32'(mem_rd), 32'(e_rd));
      if (e_rd) check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("left", 32'(left), 32'(e_left));
      check("right", 32'(right), 32'(e_right));
      check("held_l", 32'(dut.held_l_q), 32'(e_held_l));
      check("held_r", 32'(dut.held_r_q), 32'(e_held_r));
    end
  end

  // Observation for the literal checks.
  logic [7:0]  rd_q[$];
  int          rd_t[$];
  logic [15:0] held_q[$];
  logic [15:0] last_held = 16'h8080;
  int cyc = 0, done_cnt = 0, done_t = 0, busy_cnt = 0, ones_l = 0, ones_r = 0;
  logic [31:0] lhist = '0;

  task automatic clr();
    rd_q.delete(); rd_t.delete(); held_q.delete();
    done_cnt = 0; busy_cnt = 0; ones_l = 0; ones_r = 0; lhist = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_rd) begin rd_q.push_back(mem_addr); rd_t.push_back(cyc); end
      if (done) begin done_cnt++; done_t = cyc; end
      if (busy) busy_cnt++;
      if (left) ones_l++;
      if (right) ones_r++;
      lhist = {lhist[30:0], left};
      if ({dut.held_l_q, dut.held_r_q} != last_held) begin
        last_held = {dut.held_l_q, dut.held_r_q};
        held_q.push_back(last_held);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; run(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; run(1); stop = 1'b0;
  endtask

  task automatic check_reads(input string nm, input logic [7:0] exp[], input int n);
    check({nm, "_nreads"}, 32'(rd_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++)
      check({nm, "_addr"}, 32'(rd_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp2[] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] exp3[] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
    logic [7:0] exp5[] = '{8'h10, 8'h11};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hFF; mem[8'h11] = 8'h00; mem[8'h12] = 8'h40; mem[8'h13] = 8'hC0;
    mem[8'h20] = 8'h40; mem[8'h21] = 8'hFF;

    // 1: reset and idle
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    run(2);
    check("t1_rst_busy", 32'(busy), 32'd0);
    check("t1_rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    clr();
    run(4);
    check("t1_first4", 32'(lhist[3:0]), 32'b0010);
    run(96);
    check("t1_ones_l", 32'(ones_l), 32'd49);
    check("t1_ones_r", 32'(ones_r), 32'd49);
    check("t1_reads", 32'(rd_q.size()), 32'd0);
    check("t1_busy", 32'(busy_cnt), 32'd0);
    check("t1_held", 32'({dut.held_l_q, dut.held_r_q}), 32'h8080);

    // 2: one-shot, two frames
    base_addr = 8'h10; frame_count = 7'd2; loop = 1'b0;
    clr();
    pulse_start();
    run(30);
    check_reads("t2", exp2, 4);
    if (rd_t.size() >= 3) check("t2_period", 32'(rd_t[2] - rd_t[0]), 32'd8);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    if (rd_t.size() >= 3) check("t2_done_pos", 32'(done_t - rd_t[2]), 32'd3);
    check("t2_nheld", 32'(held_q.size()), 32'd2);
    if (held_q.size() >= 2) begin
      check("t2_held0", 32'(held_q[0]), 32'hFF00);
      check("t2_held1", 32'(held_q[1]), 32'h8080);
    end
    check("t2_busy_end", 32'(busy), 32'd0);

    // 3: loop for five frame periods, then stop
    loop = 1'b1;
    clr();
    pulse_start();
    run(44);
    check_reads("t3", exp3, 10);
    check("t3_done", 32'(done_cnt), 32'd0);
    pulse_stop();
    check("t3_stop_busy", 32'(busy), 32'd0);
    check("t3_stop_held", 32'({dut.held_l_q, dut.held_r_q}), 32'h8080);
    run(5);
    check("t3_stop_done", 32'(done_cnt), 32'd0);

    // 4: zero-length start
    frame_count = 7'd0;
    clr();
    pulse_start();
    check("t4_done_next", 32'(done_cnt), 32'd1);
    run(10);
    check("t4_done_once", 32'(done_cnt), 32'd1);
    check("t4_busy", 32'(busy_cnt), 32'd0);
    check("t4_reads", 32'(rd_q.size()), 32'd0);

    // 5: start+stop together, then stop during RD_R
    frame_count = 7'd2; loop = 1'b0;
    clr();
    start = 1'b1; stop = 1'b1; run(1); start = 1'b0; stop = 1'b0;
    run(5);
    check("t5_ss_busy", 32'(busy_cnt), 32'd0);
    check("t5_ss_done", 32'(done_cnt), 32'd0);
    clr();
    pulse_start();
    run(9);
    pulse_stop();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_held", 32'({dut.held_l_q, dut.held_r_q}), 32'h8080);
    run(5);
    check("t5_done", 32'(done_cnt), 32'd0);
    check_reads("t5", exp5, 2);

    // reset in the middle of a frame
    loop = 1'b1;
    pulse_start();
    run(17);
    reset = 1'b1; run(1); reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_held", 32'({dut.held_l_q, dut.held_r_q}), 32'h8080);
    run(3);

    // 6: density with held 0x40 / 0xFF
    base_addr = 8'h20; frame_count = 7'd1; loop = 1'b1;
    clr();
    pulse_start();
    run(12);
    ones_l = 0; ones_r = 0;
    run(256);
    check("t6_ones_40", 32'(ones_l), 32'd64);
    check("t6_ones_ff", 32'(ones_r), 32'd255);
    pulse_stop();
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
